// File: rtl/infra_rst_seq_pkg.sv
// Shared state encodings and counter sizing for the infrastructure reset sequencer.
package infra_rst_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        WAIT_RDY  = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        HOLD      = 3'd4
    } seq_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/infra_rst_sync.sv
// Two-flop synchroniser for a single asynchronous level, cleared by an async active-low reset.
module infra_rst_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/infra_rst_sequencer.sv
// Ordered release of domain resets after MMCM lock and IDELAYCTRL ready, with lock-loss and
// soft re-sequencing. Optional WAIT_RDY timeout enabled by defining RST_SEQ_TIMEOUT_EN.
module infra_rst_sequencer
    import infra_rst_seq_pkg::*;
#(
    parameter int N_STAGES    = 3,
    parameter int STAGE_DELAY = 16,
    parameter int HOLD_CYCLES = 32,
    parameter int TIMEOUT     = 4096
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                pll_lock,
    input  logic                idelay_rdy,
    input  logic                soft_rst_req,
    output logic [N_STAGES-1:0] rst_out,
    output logic                seq_done,
    output logic [2:0]          seq_state,
    output logic                timeout_err
);

    localparam int CNT_W = cnt_width(STAGE_DELAY, HOLD_CYCLES, TIMEOUT);
    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] SD_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STAGES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
`endif

    logic lock_s;
    logic rdy_s;

    seq_state_t          state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [N_STAGES-1:0] rst_reg, rst_next;
    logic                err_set;

    infra_rst_sync u_sync_lock (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    infra_rst_sync u_sync_rdy (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (idelay_rdy),
        .q     (rdy_s)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            idx     <= '0;
            rst_reg <= '1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            rst_reg <= rst_next;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        rst_next = rst_reg;
        err_set  = 1'b0;
        case (state)
            WAIT_LOCK: begin
                rst_next = '1;
                if (lock_s) begin
                    state_n = WAIT_RDY;
                    cnt_n   = '0;
                end
            end
            WAIT_RDY: begin
                if (rdy_s) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
`ifdef RST_SEQ_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    err_set = 1'b1;
                    state_n = RELEASE;
                    cnt_n   = '0;
                    idx_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
`endif
            end
            RELEASE: begin
                // Stages are cleared strictly by index, so bits can only drop in order.
                if (cnt == SD_LAST) begin
                    rst_next[idx] = 1'b0;
                    cnt_n         = '0;
                    idx_n         = idx + 1'b1;
                    if (idx == LAST_IDX) state_n = RUN;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            RUN: begin
                if (soft_rst_req) begin
                    state_n  = HOLD;
                    cnt_n    = '0;
                    rst_next = '1;
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) state_n = WAIT_LOCK;
                else                  cnt_n   = cnt_inc;
            end
            default: begin
                state_n  = WAIT_LOCK;
                rst_next = '1;
            end
        endcase
        // Lock loss overrides every other transition, including a stage release this cycle.
        if (state != WAIT_LOCK && !lock_s) begin
            state_n  = WAIT_LOCK;
            cnt_n    = '0;
            rst_next = '1;
        end
    end

`ifdef RST_SEQ_TIMEOUT_EN
    logic err_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)   err_reg <= 1'b0;
        else if (err_set) err_reg <= 1'b1;
    end

    assign timeout_err = err_reg;
`else
    logic unused_err;
    assign unused_err  = err_set;
    assign timeout_err = 1'b0;
`endif

    assign rst_out   = rst_reg;
    assign seq_done  = (state == RUN);
    assign seq_state = state;

endmodule

// File: tb/tb_infra_rst_sequencer.sv
// Scoreboard bench for infra_rst_sequencer: per-cycle expected outputs queued, compared each negedge.
module tb_infra_rst_sequencer;

    localparam int N  = 3;
    localparam int SD = 4;
    localparam int HC = 8;
    localparam int TO = 64;

    localparam logic [2:0] S_WL   = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_REL  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    typedef struct packed {
        logic [2:0] rst;
        logic       done;
        logic [2:0] st;
        logic       err;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       pll_lock;
    logic       idelay_rdy;
    logic       soft_rst_req;
    logic [2:0] rst_out;
    logic       seq_done;
    logic [2:0] seq_state;
    logic       timeout_err;

    exp_t sb[$];
    logic exp_err = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    infra_rst_sequencer #(
        .N_STAGES    (N),
        .STAGE_DELAY (SD),
        .HOLD_CYCLES (HC),
        .TIMEOUT     (TO)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .pll_lock     (pll_lock),
        .idelay_rdy   (idelay_rdy),
        .soft_rst_req (soft_rst_req),
        .rst_out      (rst_out),
        .seq_done     (seq_done),
        .seq_state    (seq_state),
        .timeout_err  (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic push(input int n, input logic [2:0] r, input logic [2:0] s);
        exp_t e;
        e.rst  = r;
        e.done = (s == S_RUN);
        e.st   = s;
        e.err  = exp_err;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Expected outputs from the first RELEASE cycle through a few cycles of RUN.
    task automatic push_release();
        logic [2:0] mask;
        mask = 3'b111;
        for (int s = 0; s < N; s++) begin
            push(SD, mask, S_REL);
            mask[s] = 1'b0;
        end
        push(3, 3'b000, S_RUN);
    endtask

    task automatic test_reset();
        sys_rst_n    = 1'b0;
        pll_lock     = 1'b0;
        idelay_rdy   = 1'b0;
        soft_rst_req = 1'b0;
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if ({rst_out, seq_done, seq_state, timeout_err} !== {3'b111, 1'b0, S_WL, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: rst_out=%b done=%b state=%0d err=%b, want 111 0 0 0",
                     rst_out, seq_done, seq_state, timeout_err);
        end
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if ({rst_out, seq_state} !== {3'b111, S_WL}) begin
            n_fail++;
            $display("FAIL reset_idle: rst_out=%b state=%0d, want 111 0", rst_out, seq_state);
        end
    endtask

    task automatic test_sequence();
        exp_t e;
        pll_lock = 1'b1;
        push(2, 3'b111, S_WL);
        push(8, 3'b111, S_WR);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; sb.size() > 0; i++) begin
                @(negedge sys_clk);
                e = sb.pop_front();
                n_checks++;
                if ({rst_out, seq_done, seq_state, timeout_err} !== e) begin
                    n_fail++;
                    $display("FAIL sequence p%0d i=%0d: got %b %b %0d %b, want %b %b %0d %b", pass, i,
                             rst_out, seq_done, seq_state, timeout_err, e.rst, e.done, e.st, e.err);
                end
            end
            if (pass == 0) begin
                idelay_rdy = 1'b1;
                push(2, 3'b111, S_WR);
                push_release();
            end
        end
    endtask

    task automatic test_lock_loss();
        exp_t e;
        pll_lock = 1'b0;
        push(2, 3'b000, S_RUN);
        push(1, 3'b111, S_WL);
        push(1, 3'b111, S_WR);
        push_release();
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge sys_clk);
            if (i == 0) pll_lock = 1'b1;
            e = sb.pop_front();
            n_checks++;
            if ({rst_out, seq_done, seq_state, timeout_err} !== e) begin
                n_fail++;
                $display("FAIL lock_loss i=%0d: got %b %b %0d %b, want %b %b %0d %b", i,
                         rst_out, seq_done, seq_state, timeout_err, e.rst, e.done, e.st, e.err);
            end
        end
    endtask

    task automatic test_soft_reset();
        exp_t e;
        soft_rst_req = 1'b1;
        push(HC, 3'b111, S_HOLD);
        push(1, 3'b111, S_WL);
        push(1, 3'b111, S_WR);
        push_release();
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge sys_clk);
            if (i == 0) soft_rst_req = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if ({rst_out, seq_done, seq_state, timeout_err} !== e) begin
                n_fail++;
                $display("FAIL soft_reset i=%0d: got %b %b %0d %b, want %b %b %0d %b", i,
                         rst_out, seq_done, seq_state, timeout_err, e.rst, e.done, e.st, e.err);
            end
        end
    endtask

    // Lock is lost exactly on the edge where stage 1 would otherwise be released.
    task automatic test_lock_vs_release();
        exp_t e;
        pll_lock = 1'b0;
        push(2, 3'b000, S_RUN);
        push(1, 3'b111, S_WL);
        push(1, 3'b111, S_WR);
        push(SD, 3'b111, S_REL);
        push(SD, 3'b110, S_REL);
        push(4, 3'b111, S_WL);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge sys_clk);
            if (i == 0) pll_lock = 1'b1;
            if (i == 5) idelay_rdy = 1'b0;
            if (i == 9) pll_lock = 1'b0;
            e = sb.pop_front();
            n_checks++;
            if ({rst_out, seq_done, seq_state, timeout_err} !== e) begin
                n_fail++;
                $display("FAIL lock_vs_release i=%0d: got %b %b %0d %b, want %b %b %0d %b", i,
                         rst_out, seq_done, seq_state, timeout_err, e.rst, e.done, e.st, e.err);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        pll_lock   = 1'b1;
        idelay_rdy = 1'b1;
        push(2, 3'b111, S_WL);
        push(1, 3'b111, S_WR);
        push(SD, 3'b111, S_REL);
        push(2, 3'b110, S_REL);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge sys_clk);
            e = sb.pop_front();
            n_checks++;
            if ({rst_out, seq_done, seq_state, timeout_err} !== e) begin
                n_fail++;
                $display("FAIL async_pre i=%0d: got %b %b %0d %b, want %b %b %0d %b", i,
                         rst_out, seq_done, seq_state, timeout_err, e.rst, e.done, e.st, e.err);
            end
        end
        #2 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rst_out, seq_done, seq_state, timeout_err} !== {3'b111, 1'b0, S_WL, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %b %b %0d %b, want 111 0 0 0",
                     rst_out, seq_done, seq_state, timeout_err);
        end
        pll_lock   = 1'b0;
        idelay_rdy = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if ({rst_out, seq_state} !== {3'b111, S_WL}) begin
            n_fail++;
            $display("FAIL async_held: rst_out=%b state=%0d, want 111 0", rst_out, seq_state);
        end
        sys_rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        exp_t e;
        pll_lock = 1'b1;
        push(2, 3'b111, S_WL);
`ifdef RST_SEQ_TIMEOUT_EN
        push(TO, 3'b111, S_WR);
        exp_err = 1'b1;
        push_release();
`else
        push(TO + 10, 3'b111, S_WR);
`endif
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge sys_clk);
            e = sb.pop_front();
            n_checks++;
            if ({rst_out, seq_done, seq_state, timeout_err} !== e) begin
                n_fail++;
                $display("FAIL timeout i=%0d: got %b %b %0d %b, want %b %b %0d %b", i,
                         rst_out, seq_done, seq_state, timeout_err, e.rst, e.done, e.st, e.err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_lock_loss();
        test_soft_reset();
        test_lock_vs_release();
        test_async_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
